tone_divider: RTL and testbench
===============================

TONE_DIVIDER -- requirements
Module: tone_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the half-period counter and half_period width.
REQ-002 SHALL have parameter DUR_W, default 16, giving the burst length and remaining-period counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: global enable; 0 silences the output and aborts any burst.
REQ-006 SHALL have port half_period, input, WIDTH bits: half-period in clk cycles; 0 means silent.
REQ-007 SHALL have port burst_mode, input, 1 bit: 0 selects continuous tone, 1 selects counted bursts.
REQ-008 SHALL have port burst_len, input, DUR_W bits: number of full sclk periods in one burst.
REQ-009 SHALL have port start, input, 1 bit: single-cycle burst request.
REQ-010 SHALL have port sclk, output, 1 bit: the divided square wave driving the speaker.
REQ-011 SHALL have port busy, output, 1 bit: high while a burst is running.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes normally.

Function
REQ-013 SHALL keep the internal registers count (WIDTH), hp_q (WIDTH), rem (DUR_W), and a state register with states IDLE and RUN.
REQ-014 SHALL define a toggle event as: tone active, hp_q != 0, and count == hp_q-1; on that cycle count<=0, sclk<=~sclk, and hp_q<=half_period.
REQ-015 SHALL otherwise increment count by 1 per cycle while the tone is active, giving a period of exactly 2*hp_q cycles and a 50% duty cycle.
REQ-016 SHALL treat the tone as active when state=IDLE with burst_mode=0 and en=1, or when state=RUN.
REQ-017 SHALL, when the tone is inactive or hp_q==0, hold count at 0, drive sclk to 0 on the next cycle, and load hp_q from half_period every cycle.
REQ-018 SHALL apply half_period changes during an active tone only at toggle events, so no truncated half-period occurs; a newly loaded 0 forces sclk to 0 on the next cycle.
REQ-019 SHALL treat a half_period of 1 as valid, toggling sclk every cycle for a period of 2 cycles.
REQ-020 SHALL sample burst_mode only in IDLE; changing it during RUN has no effect until the burst ends.
REQ-021 SHALL accept start in IDLE only when burst_mode=1, en=1, half_period != 0, and burst_len != 0; on acceptance hp_q<=half_period, rem<=burst_len, count<=0, sclk<=0, busy<=1, and state goes to RUN.
REQ-022 SHALL ignore start in any other case, including while in RUN, with no done pulse.
REQ-023 SHALL, in RUN, decrement rem at each toggle event where sclk goes 1->0, marking one complete period.
REQ-024 SHALL, when that decrement takes rem from 1 to 0, go to IDLE with sclk<=0 and busy<=0, and pulse done=1 for exactly 1 cycle.
REQ-025 SHALL, if en=0 during RUN, abort to IDLE on the next edge with sclk=0 and busy=0, and SHALL NOT pulse done.
REQ-026 SHALL, if hp_q becomes 0 during RUN, hold sclk low, freeze rem and stay in RUN until a nonzero value is loaded or en=0.
REQ-027 SHALL let done and a new accepted start occur back-to-back: start in the cycle after done begins a new burst.

Reset
REQ-028 SHALL, while rst=1, set count=0, hp_q=0, rem=0, state=IDLE, sclk=0, busy=0 and done=0; rst has priority over all inputs, including mid-burst.
REQ-029 SHALL, on the first cycle after rst deasserts, load hp_q from half_period and start counting from 0.

Verification
REQ-030 SHALL cover continuous tone: WIDTH=16, half_period=4, burst_mode=0, en=1 -> sclk toggles every 4 cycles, period 8, first rise 4-5 cycles after reset release.
REQ-031 SHALL cover a mid-period frequency change: half_period changes from 4 to 2 two cycles after a toggle -> the current half-period still lasts 4 cycles and subsequent half-periods last 2.
REQ-032 SHALL cover a burst: burst_mode=1, half_period=3, burst_len=2, start pulse -> busy high, exactly 2 periods (12 cycles), then done pulse 1 cycle, busy=0, sclk=0.
REQ-033 SHALL cover abort: en drops to 0 mid-burst -> sclk=0 and busy=0 next cycle, no done; a later start is accepted normally.
REQ-034 SHALL cover ignored starts: start with burst_len=0, with half_period=0, and during RUN -> no state change, no done.
REQ-035 SHALL cover reset mid-operation: rst asserted mid-burst with sclk=1 -> all outputs 0 next cycle; boundary half_period=1 gives a period-2 clock and 16'hFFFF gives a period of 131070 cycles.

Source files
------------

// File: rtl/tone_divider.sv
// Square-wave tone generator for a speaker: divides clk by 2*half_period,
// either continuously or as counted bursts of full periods.
module tone_divider #(
  parameter int WIDTH = 16,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] half_period,
  input  logic             burst_mode,
  input  logic [DUR_W-1:0] burst_len,
  input  logic             start,
  output logic             sclk,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] HP_ONE  = WIDTH'(1);
  localparam logic [DUR_W-1:0] REM_ONE = DUR_W'(1);

  state_t           state, state_d;
  logic [WIDTH-1:0] count, count_d;
  logic [WIDTH-1:0] hp_q, hp_d;
  logic [DUR_W-1:0] rem, rem_d;
  logic             sclk_d, busy_d, done_d;
  logic             active, at_toggle, accept;

  // Next-state logic; half_period is only ever latched into hp_q at a toggle
  // or while the divider is parked, so a running half-period is never cut short.
  always_comb begin
    active    = (state == RUN) || ((state == IDLE) && !burst_mode && en);
    at_toggle = active && (hp_q != '0) && (count == (hp_q - HP_ONE));
    accept    = (state == IDLE) && burst_mode && en && start &&
                (half_period != '0) && (burst_len != '0);

    state_d = state;
    count_d = count;
    hp_d    = hp_q;
    rem_d   = rem;
    sclk_d  = sclk;
    busy_d  = busy;
    done_d  = 1'b0;

    if (accept) begin
      state_d = RUN;
      hp_d    = half_period;
      rem_d   = burst_len;
      count_d = '0;
      sclk_d  = 1'b0;
      busy_d  = 1'b1;
    end else if ((state == RUN) && !en) begin
      state_d = IDLE;
      count_d = '0;
      hp_d    = half_period;
      sclk_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (!active || (hp_q == '0)) begin
      count_d = '0;
      hp_d    = half_period;
      sclk_d  = 1'b0;
    end else if (at_toggle) begin
      count_d = '0;
      hp_d    = half_period;
      sclk_d  = ~sclk;
      // A falling edge closes one full period of the burst.
      if ((state == RUN) && sclk) begin
        rem_d = rem - REM_ONE;
        if (rem == REM_ONE) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end else begin
      count_d = count + HP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      hp_q  <= '0;
      rem   <= '0;
      sclk  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      hp_q  <= hp_d;
      rem   <= rem_d;
      sclk  <= sclk_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_tone_divider.sv
// Scoreboard bench for tone_divider: each stimulus cycle queues the hand-derived
// {sclk,busy,done} expected after the next edge; a monitor pops and compares.
module tb_tone_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] half_period;
  logic        burst_mode;
  logic [15:0] burst_len;
  logic        start;
  logic        sclk, busy, done;

  typedef struct {
    string      name;
    logic [2:0] exp;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int   testsRun = 0;
  int   testsFailed = 0;

  tone_divider #(.WIDTH(16), .DUR_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .half_period(half_period),
    .burst_mode(burst_mode), .burst_len(burst_len), .start(start),
    .sclk(sclk), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    testsRun++;
    if ({sclk, busy, done} !== e.exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: sclk/busy/done got %b%b%b expected %b%b%b at %0t",
               e.name, sclk, busy, done, e.exp[2], e.exp[1], e.exp[0], $time);
    end
  endtask

  // Queue one expected result for the edge following the current inputs.
  task automatic applyStimulus(input string name, input logic s, input logic b, input logic d);
    exp_t e;
    e.name = name;
    e.exp  = {s, b, d};
    sbq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        monE = sbq.pop_front();
        checkOutput(monE);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; half_period = 16'd4; burst_mode = 1'b0;
    burst_len = 16'd0; start = 1'b0;

    // Reset wins over an enabled continuous tone.
    for (int i = 0; i < 3; i++) applyStimulus("reset", 0, 0, 0);

    // Continuous tone, half_period=4; first rise 5 edges after release.
    rst = 1'b0;
    applyStimulus("cont_load", 0, 0, 0);
    for (int k = 1; k <= 18; k++) applyStimulus("cont_hp4", ((k / 4) % 2) == 1, 0, 0);

    // Change to 2 two cycles after the toggle at k=16: current half stays 4.
    half_period = 16'd2;
    applyStimulus("chg_keep", 0, 0, 0);
    applyStimulus("chg_edge", 1, 0, 0);
    for (int k = 21; k <= 28; k++) applyStimulus("chg_hp2", (((k - 20) / 2) % 2) == 0, 0, 0);

    en = 1'b0;
    applyStimulus("en_off", 0, 0, 0);
    applyStimulus("en_off_hold", 0, 0, 0);

    // Burst of 2 periods at half_period=3, with ignored start and burst_mode flip mid-run.
    en = 1'b1; burst_mode = 1'b1; half_period = 16'd3; burst_len = 16'd2;
    applyStimulus("burst_idle", 0, 0, 0);
    start = 1'b1;
    applyStimulus("burst_accept", 0, 1, 0);
    start = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      start = (j == 5);
      if (j == 7) burst_mode = 1'b0;
      if (j == 9) burst_mode = 1'b1;
      applyStimulus("burst_run", ((j / 3) % 2) == 1, 1, 0);
    end
    start = 1'b0;
    applyStimulus("burst_done", 0, 0, 1);

    // Back-to-back start, boundary half_period=1 with a single period.
    half_period = 16'd1; burst_len = 16'd1; start = 1'b1;
    applyStimulus("b2b_accept", 0, 1, 0);
    start = 1'b0;
    applyStimulus("b2b_high", 1, 1, 0);
    applyStimulus("b2b_done", 0, 0, 1);
    applyStimulus("b2b_after", 0, 0, 0);

    // Abort with en=0 while sclk is high; no done afterwards.
    half_period = 16'd3; burst_len = 16'd4; start = 1'b1;
    applyStimulus("abort_accept", 0, 1, 0);
    start = 1'b0;
    for (int j = 1; j <= 4; j++) applyStimulus("abort_run", ((j / 3) % 2) == 1, 1, 0);
    en = 1'b0;
    applyStimulus("abort_edge", 0, 0, 0);
    for (int j = 0; j < 3; j++) applyStimulus("abort_nodone", 0, 0, 0);

    // A later start is accepted; then reset lands mid-burst with sclk high.
    en = 1'b1; start = 1'b1;
    applyStimulus("restart_accept", 0, 1, 0);
    start = 1'b0;
    for (int j = 1; j <= 3; j++) applyStimulus("restart_run", ((j / 3) % 2) == 1, 1, 0);
    rst = 1'b1;
    applyStimulus("rst_mid", 0, 0, 0);
    applyStimulus("rst_hold", 0, 0, 0);
    rst = 1'b0;
    applyStimulus("rst_release", 0, 0, 0);

    // Ignored starts: burst_len=0, half_period=0, en=0.
    burst_len = 16'd0; start = 1'b1;
    applyStimulus("ign_len0", 0, 0, 0);
    start = 1'b0;
    applyStimulus("ign_len0_after", 0, 0, 0);
    burst_len = 16'd2; half_period = 16'd0; start = 1'b1;
    applyStimulus("ign_hp0", 0, 0, 0);
    start = 1'b0;
    applyStimulus("ign_hp0_after", 0, 0, 0);
    half_period = 16'd3; en = 1'b0; start = 1'b1;
    applyStimulus("ign_en0", 0, 0, 0);
    start = 1'b0; en = 1'b1;
    applyStimulus("ign_en0_after", 0, 0, 0);

    // half_period drops to 0 mid-burst: sclk parks low, rem frozen, then resumes.
    half_period = 16'd2; burst_len = 16'd2; start = 1'b1;
    applyStimulus("hp0run_accept", 0, 1, 0);
    start = 1'b0;
    applyStimulus("hp0run_j1", 0, 1, 0);
    half_period = 16'd0;
    applyStimulus("hp0run_toggle", 1, 1, 0);
    for (int j = 3; j <= 6; j++) applyStimulus("hp0run_hold", 0, 1, 0);
    half_period = 16'd2;
    for (int m = 0; m <= 7; m++) applyStimulus("hp0run_resume", ((m / 2) % 2) == 1, 1, 0);
    applyStimulus("hp0run_done", 0, 0, 1);
    applyStimulus("hp0run_after", 0, 0, 0);

    // Continuous half_period=1: period of 2 cycles.
    half_period = 16'd1;
    applyStimulus("hp1_load", 0, 0, 0);
    burst_mode = 1'b0;
    for (int k = 1; k <= 8; k++) applyStimulus("hp1_cont", (k % 2) == 1, 0, 0);

    // half_period=16'hFFFF: first half-period lasts 65535 cycles.
    en = 1'b0; half_period = 16'hFFFF;
    applyStimulus("hpmax_load", 0, 0, 0);
    en = 1'b1;
    for (int k = 1; k <= 65540; k++) applyStimulus("hpmax_cont", k >= 65535, 0, 0);

    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (sbq.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
